pipeline_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 10 +
 rtl/pipeline_ctrl_if.sv | 39 +++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU control types
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard status in, pipe-register controls out
interface pipeline_ctrl_if;
    logic       ihit;
    logic       dhit;
    logic       mem_dREN;
    logic       mem_dWEN;
    logic       ex_dREN;
    logic [4:0] ex_wsel;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_halt;
    logic       ex_redirect;
    logic       wb_halt;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_flush;
    logic       exmem_en;
    logic       exmem_flush;
    logic       memwb_en;
    logic       memwb_flush;

    modport master (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               id_uses_rt, id_halt, ex_redirect, wb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush
    );

    modport slave (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               id_uses_rt, id_halt, ex_redirect, wb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush
    );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard between ID/EX load and IF/ID sources
module hazard_detect (
    input  logic       ex_dREN,
    input  logic [4:0] ex_wsel,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       loaduse
);
    logic rs_match;
    logic rt_match;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign rs_match = (ex_wsel == id_rs);
    assign rt_match = id_uses_rt & (ex_wsel == id_rt);
    assign loaduse  = ex_dREN & (ex_wsel != 5'd0) & (rs_match | rt_match);
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush sequencer with halt drain and perf counters
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    pipeline_ctrl_if.master  bus,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import cpu_types_pkg::*;

    pipe_ctrl_state_t state;
    logic             halt_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic dstall;
    logic loaduse;
    logic stall_win;
    logic flush_win;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, memwb_flush;

    assign dstall = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;

    hazard_detect u_hazard_detect (
        .ex_dREN    (bus.ex_dREN),
        .ex_wsel    (bus.ex_wsel),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .loaduse    (loaduse)
    );

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        stall_win   = 1'b0;
        flush_win   = 1'b0;
        if (RST) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (dstall) begin
                        // hold IF..EX/MEM; only a bubble moves on into WB
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        stall_win   = 1'b1;
                    end else if (state == DRAIN) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end else if (bus.ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_win  = 1'b1;
                    end else if (loaduse) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_win  = 1'b1;
                    end else begin
                        // an I-miss and a halt entering EX both turn fetch off
                        if (!bus.ihit || bus.id_halt) begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                        end
                        stall_win = ~bus.ihit;
                    end
                end
                default: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            halt_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.id_halt && !dstall && !bus.ex_redirect && !loaduse) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.wb_halt) begin
                        state  <= HALTED;
                        halt_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= HALTED;
                    halt_q <= 1'b1;
                end
            endcase
            if (stall_win && !(&stall_q)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_win && !(&flush_q)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_en    = exmem_en;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_en    = memwb_en;
    assign bus.memwb_flush = memwb_flush;

    assign halt      = halt_q & ~RST;
    assign stall_cnt = RST ? '0 : stall_q;
    assign flush_cnt = RST ? '0 : flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - vector, sequence and random-model checks for pipeline_ctrl
module tb_pipeline_ctrl;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       mem_dREN;
        logic       mem_dWEN;
        logic       ex_dREN;
        logic [4:0] ex_wsel;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       id_halt;
        logic       ex_redirect;
        logic       wb_halt;
    } in_t;

    typedef struct {
        in_t        i;
        logic [8:0] exp;
    } vec_t;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
    localparam logic [8:0] E_DEF = 9'b110101010;
    localparam logic [8:0] E_LU  = 9'b000111010;
    localparam logic [8:0] E_IS  = 9'b011101010;
    localparam logic [8:0] E_DS  = 9'b000000011;
    localparam logic [8:0] E_RD  = 9'b111111010;
    localparam logic [8:0] E_HLT = 9'b000000000;
    localparam logic [8:0] E_RST = 9'b011111111;

    logic        CLK;
    logic        RST;
    logic        RST4;
    logic        halt;
    logic        halt4;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [3:0]  stall_cnt4;
    logic [3:0]  flush_cnt4;

    int total;
    int bad;

    pipeline_ctrl_if bus();
    pipeline_ctrl_if bus4();

    pipeline_ctrl #(.CNT_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .halt      (halt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .CLK       (CLK),
        .RST       (RST4),
        .bus       (bus4),
        .halt      (halt4),
        .stall_cnt (stall_cnt4),
        .flush_cnt (flush_cnt4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ctl();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush};
    endfunction

    function automatic in_t mk(bit ih, bit dh, bit dr, bit dw, bit er, int ws, int rs, int rt,
                               bit urt, bit idh, bit red);
        in_t r;
        r.ihit        = ih;
        r.dhit        = dh;
        r.mem_dREN    = dr;
        r.mem_dWEN    = dw;
        r.ex_dREN     = er;
        r.ex_wsel     = 5'(ws);
        r.id_rs       = 5'(rs);
        r.id_rt       = 5'(rt);
        r.id_uses_rt  = urt;
        r.id_halt     = idh;
        r.ex_redirect = red;
        r.wb_halt     = 1'b0;
        return r;
    endfunction

    task automatic apply(input in_t i);
        bus.ihit        = i.ihit;
        bus.dhit        = i.dhit;
        bus.mem_dREN    = i.mem_dREN;
        bus.mem_dWEN    = i.mem_dWEN;
        bus.ex_dREN     = i.ex_dREN;
        bus.ex_wsel     = i.ex_wsel;
        bus.id_rs       = i.id_rs;
        bus.id_rt       = i.id_rt;
        bus.id_uses_rt  = i.id_uses_rt;
        bus.id_halt     = i.id_halt;
        bus.ex_redirect = i.ex_redirect;
        bus.wb_halt     = i.wb_halt;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        RST = 1'b0;
    endtask

    // Reference: modes 0=running, 1=draining, 2=halted. Returns expected controls and
    // which counter (if any) the cycle charges, plus the mode after the edge.
    function automatic logic [8:0] model(input int mode, input in_t i, input bit rst,
                                         output bit st, output bit fl, output int nmode);
        bit dst;
        bit lu;
        dst = (i.mem_dREN || i.mem_dWEN) && !i.dhit;
        lu  = i.ex_dREN && (i.ex_wsel != 0) &&
              ((i.ex_wsel == i.id_rs) || (i.id_uses_rt && (i.ex_wsel == i.id_rt)));
        st = 0;
        fl = 0;
        nmode = mode;
        if (rst) begin
            nmode = 0;
            return E_RST;
        end
        if (mode == 2) return E_HLT;
        if (mode == 1 && i.wb_halt) nmode = 2;
        if (dst) begin
            st = 1;
            return E_DS;
        end
        if (mode == 1) return E_IS;
        if (i.ex_redirect) begin
            fl = 1;
            return E_RD;
        end
        if (lu) begin
            st = 1;
            return E_LU;
        end
        if (i.id_halt) nmode = 1;
        if (!i.ihit) begin
            st = 1;
            return E_IS;
        end
        if (i.id_halt) return E_IS;
        return E_DEF;
    endfunction

    function automatic in_t rnd_in();
        in_t r;
        r.ihit        = ($urandom % 4) != 0;
        r.dhit        = ($urandom % 3) != 0;
        r.mem_dREN    = ($urandom % 4) == 0;
        r.mem_dWEN    = ($urandom % 8) == 0;
        r.ex_dREN     = ($urandom % 3) == 0;
        r.ex_wsel     = 5'($urandom_range(0, 7));
        r.id_rs       = 5'($urandom_range(0, 7));
        r.id_rt       = 5'($urandom_range(0, 7));
        r.id_uses_rt  = $urandom_range(0, 1) == 1;
        r.id_halt     = ($urandom % 30) == 0;
        r.ex_redirect = ($urandom % 8) == 0;
        r.wb_halt     = ($urandom % 4) == 0;
        return r;
    endfunction

    initial begin
        vec_t vecs[$];
        int   exp_st;
        int   exp_fl;
        int   mode;
        longint scnt;
        longint fcnt;

        total = 0;
        bad   = 0;
        RST   = 1'b1;
        RST4  = 1'b1;
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus4.ihit = 1'b1; bus4.dhit = 1'b1; bus4.mem_dREN = 1'b0; bus4.mem_dWEN = 1'b0;
        bus4.ex_dREN = 1'b0; bus4.ex_wsel = 5'd0; bus4.id_rs = 5'd0; bus4.id_rt = 5'd0;
        bus4.id_uses_rt = 1'b0; bus4.id_halt = 1'b0; bus4.ex_redirect = 1'b0; bus4.wb_halt = 1'b0;

        @(negedge CLK);
        chk("reset_ctl", 64'(ctl()), 64'(E_RST));
        chk("reset_halt", 64'(halt), 64'd0);
        chk("reset_stall", 64'(stall_cnt), 64'd0);
        chk("reset_flush", 64'(flush_cnt), 64'd0);
        next_cycle();
        RST  = 1'b0;
        RST4 = 1'b0;

        // single-cycle priority vectors, all evaluated in RUN
        vecs.push_back('{mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_DEF});
        vecs.push_back('{mk(1, 1, 0, 0, 1, 5, 5, 0, 0, 0, 0), E_LU});
        vecs.push_back('{mk(1, 1, 0, 0, 1, 7, 3, 7, 1, 0, 0), E_LU});
        vecs.push_back('{mk(1, 1, 0, 0, 1, 7, 3, 7, 0, 0, 0), E_DEF});
        vecs.push_back('{mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0), E_DEF});
        vecs.push_back('{mk(1, 1, 0, 0, 0, 5, 5, 5, 1, 0, 0), E_DEF});
        vecs.push_back('{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_IS});
        vecs.push_back('{mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), E_DS});
        vecs.push_back('{mk(0, 0, 0, 1, 1, 4, 4, 0, 0, 0, 1), E_DS});
        vecs.push_back('{mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), E_DEF});
        vecs.push_back('{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), E_RD});
        vecs.push_back('{mk(1, 1, 0, 0, 1, 6, 6, 0, 0, 0, 1), E_RD});
        vecs.push_back('{mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), E_RD});
        vecs.push_back('{mk(0, 1, 0, 0, 1, 2, 1, 2, 1, 0, 0), E_LU});
        vecs.push_back('{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_DEF});
        exp_st = 0;
        exp_fl = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k].i);
            @(negedge CLK);
            chk($sformatf("vec%0d", k), 64'(ctl()), 64'(vecs[k].exp));
            if (vecs[k].exp == E_LU || vecs[k].exp == E_IS || vecs[k].exp == E_DS) exp_st++;
            if (vecs[k].exp == E_RD) exp_fl++;
            next_cycle();
        end
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        chk("vec_stall_cnt", 64'(stall_cnt), 64'(exp_st));
        chk("vec_flush_cnt", 64'(flush_cnt), 64'(exp_fl));
        next_cycle();

        // load-use charges exactly one stall
        do_reset();
        apply(mk(1, 1, 0, 0, 1, 5, 5, 0, 0, 0, 0));
        @(negedge CLK);
        chk("lu_ctl", 64'(ctl()), 64'(E_LU));
        chk("lu_cnt0", 64'(stall_cnt), 64'd0);
        next_cycle();
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        chk("lu_cnt1", 64'(stall_cnt), 64'd1);
        chk("lu_after", 64'(ctl()), 64'(E_DEF));
        next_cycle();

        // D-miss freeze holds a pending redirect until the access completes
        do_reset();
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("dmiss_freeze%0d", k), 64'(ctl()), 64'(E_DS));
            next_cycle();
        end
        apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        @(negedge CLK);
        chk("dmiss_redirect", 64'(ctl()), 64'(E_RD));
        next_cycle();
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        chk("dmiss_flush_cnt", 64'(flush_cnt), 64'd1);
        chk("dmiss_stall_cnt", 64'(stall_cnt), 64'd3);
        next_cycle();

        // I-miss for two cycles
        do_reset();
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk($sformatf("imiss%0d", k), 64'(ctl()), 64'(E_IS));
            next_cycle();
        end
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        chk("imiss_cnt", 64'(stall_cnt), 64'd2);
        next_cycle();

        // halt drain, sticky HALTED, reset release
        do_reset();
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        @(negedge CLK);
        chk("halt_enter", 64'(ctl()), 64'(E_IS));
        next_cycle();
        apply(mk(1, 1, 0, 0, 1, 3, 3, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.wb_halt = 1'b1;
            @(negedge CLK);
            chk($sformatf("drain%0d_ctl", k), 64'(ctl()), 64'(E_IS));
            chk($sformatf("drain%0d_halt", k), 64'(halt), 64'd0);
            next_cycle();
        end
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("halted%0d_ctl", k), 64'(ctl()), 64'(E_HLT));
            chk($sformatf("halted%0d_halt", k), 64'(halt), 64'd1);
            next_cycle();
        end
        RST = 1'b1;
        @(negedge CLK);
        chk("halt_rst_ctl", 64'(ctl()), 64'(E_RST));
        chk("halt_rst_halt", 64'(halt), 64'd0);
        next_cycle();
        RST = 1'b0;
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        chk("halt_release_ctl", 64'(ctl()), 64'(E_DEF));
        chk("halt_release_halt", 64'(halt), 64'd0);
        next_cycle();

        // 4-bit counters saturate at 15
        bus4.ihit = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("sat_stall%0d", k), 64'(stall_cnt4), 64'((k > 15) ? 15 : k));
        end
        bus4.ex_redirect = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("sat_flush%0d", k), 64'(flush_cnt4), 64'((k > 15) ? 15 : k));
        end
        chk("sat_stall_hold", 64'(stall_cnt4), 64'd15);
        next_cycle();

        // randomized run against the reference model
        do_reset();
        mode = 0;
        scnt = 0;
        fcnt = 0;
        for (int c = 0; c < 1500; c++) begin
            in_t        ri;
            bit         rr;
            bit         st;
            bit         fl;
            int         nm;
            logic [8:0] e;
            ri = rnd_in();
            rr = (mode == 2 && $urandom_range(0, 5) == 0) || ($urandom_range(0, 199) == 0);
            RST = rr;
            apply(ri);
            e = model(mode, ri, rr, st, fl, nm);
            @(negedge CLK);
            chk($sformatf("rnd%0d_ctl", c), 64'(ctl()), 64'(e));
            chk($sformatf("rnd%0d_halt", c), 64'(halt), 64'(!rr && mode == 2));
            chk($sformatf("rnd%0d_stall", c), 64'(stall_cnt), rr ? 64'd0 : 64'(scnt));
            chk($sformatf("rnd%0d_flush", c), 64'(flush_cnt), rr ? 64'd0 : 64'(fcnt));
            if (rr) begin
                scnt = 0;
                fcnt = 0;
            end else begin
                if (st && scnt < 64'hFFFF_FFFF) scnt++;
                if (fl && fcnt < 64'hFFFF_FFFF) fcnt++;
            end
            mode = nm;
            next_cycle();
        end
        RST = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
